// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 constants, types and classification helper
package fpu_pkg;

    localparam int          FP32_BIAS = 127;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [31:0] PINF      = 32'h7F800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {FP_NORM, FP_ZERO, FP_INF, FP_NAN} fp_class_t;

    // Denormals classify as zero: the FPU flushes them on input.
    function automatic fp_class_t fp_classify(input fp32_t v);
        if (v.exp == 8'd0)
            return FP_ZERO;
        else if (v.exp == EXP_MAX)
            return (v.man != 23'd0) ? FP_NAN : FP_INF;
        else
            return FP_NORM;
    endfunction

endpackage

// File: rtl/fsquare_round.sv
// rtl/fsquare_round.sv - normalise and round-to-nearest-even a 48-bit mantissa product
module fsquare_round
    import fpu_pkg::*;
(
    input  logic [47:0]        p,
    input  logic [7:0]         e,
    output logic [22:0]        mant,
    output logic signed [9:0]  exp_e,
    output logic               ovf,
    output logic               unf
);

    logic        n;
    logic [22:0] mant_pre;
    logic        g;
    logic        s;
    logic        inc;
    logic [23:0] sum;
    logic        c;

    always_comb begin
        n        = p[47];
        mant_pre = n ? p[46:24] : p[45:23];
        g        = n ? p[23]    : p[22];
        s        = n ? (|p[22:0]) : (|p[21:0]);
        inc      = g & (s | mant_pre[0]);
        sum      = {1'b0, mant_pre} + {23'd0, inc};
        c        = sum[23];
        mant     = c ? 23'd0 : sum[22:0];
        // Operand exponent counts twice for a square; 10 bits keep the sign.
        exp_e    = {1'b0, e, 1'b0} - 10'(FP32_BIAS) + {9'd0, n} + {9'd0, c};
        ovf      = exp_e >= 10'sd255;
        unf      = exp_e <= 10'sd0;
    end

endmodule

// File: rtl/fsquare.sv
// rtl/fsquare.sv - three-stage pipelined FP32 squarer with valid/ready handshake
module fsquare
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);

    fp32_t       xin;
    logic        en;
    logic        unused_sign;

    logic        v1_q, v1_d;
    fp_class_t   cls1_q, cls1_d;
    logic [7:0]  e1_q, e1_d;
    logic [23:0] m1_q, m1_d;

    logic        v2_q, v2_d;
    fp_class_t   cls2_q, cls2_d;
    logic [7:0]  e2_q, e2_d;
    logic [47:0] p2_q, p2_d;

    logic        v3_q, v3_d;
    logic [31:0] y_q, y_d;

    logic [11:0] ah, al;
    logic [23:0] hh, hl, lh, ll;

    logic [22:0]       r_mant;
    logic signed [9:0] r_exp;
    logic              r_ovf, r_unf;

    assign xin         = x;
    assign unused_sign = xin.sign;
    assign en          = ~v3_q | out_ready;
    assign in_ready    = en;
    assign y           = y_q;
    assign out_valid   = v3_q;

    fsquare_round u_round (
        .p     (p2_q),
        .e     (e2_q),
        .mant  (r_mant),
        .exp_e (r_exp),
        .ovf   (r_ovf),
        .unf   (r_unf)
    );

    always_comb begin
        v1_d   = v1_q;
        cls1_d = cls1_q;
        e1_d   = e1_q;
        m1_d   = m1_q;
        v2_d   = v2_q;
        cls2_d = cls2_q;
        e2_d   = e2_q;
        p2_d   = p2_q;
        v3_d   = v3_q;
        y_d    = y_q;

        // Split the 24-bit mantissa in halves; hl and lh are equal for a square.
        ah = m1_q[23:12];
        al = m1_q[11:0];
        hh = {12'd0, ah} * {12'd0, ah};
        hl = {12'd0, ah} * {12'd0, al};
        lh = {12'd0, al} * {12'd0, ah};
        ll = {12'd0, al} * {12'd0, al};

        if (en) begin
            v1_d   = in_valid;
            cls1_d = fp_classify(xin);
            e1_d   = xin.exp;
            m1_d   = {1'b1, xin.man};

            v2_d   = v1_q;
            cls2_d = cls1_q;
            e2_d   = e1_q;
            p2_d   = ({24'd0, hh} << 24) + ({24'd0, hl} << 12)
                   + ({24'd0, lh} << 12) + {24'd0, ll};

            v3_d   = v2_q;
            if (v2_q) begin
                unique case (cls2_q)
                    FP_ZERO: y_d = 32'd0;
                    FP_NAN:  y_d = QNAN;
                    FP_INF:  y_d = PINF;
                    default: begin
                        if (r_ovf)
                            y_d = PINF;
                        else if (r_unf)
                            y_d = 32'd0;
                        else
                            y_d = {1'b0, r_exp[7:0], r_mant};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            cls1_q <= FP_ZERO;
            e1_q   <= 8'd0;
            m1_q   <= 24'd0;
            v2_q   <= 1'b0;
            cls2_q <= FP_ZERO;
            e2_q   <= 8'd0;
            p2_q   <= 48'd0;
            v3_q   <= 1'b0;
            y_q    <= 32'd0;
        end else begin
            v1_q   <= v1_d;
            cls1_q <= cls1_d;
            e1_q   <= e1_d;
            m1_q   <= m1_d;
            v2_q   <= v2_d;
            cls2_q <= cls2_d;
            e2_q   <= e2_d;
            p2_q   <= p2_d;
            v3_q   <= v3_d;
            y_q    <= y_d;
        end
    end

endmodule

// File: tb/tb_fsquare.sv
// tb/tb_fsquare.sv - scoreboard bench for fsquare against an arithmetic reference model
module tb_fsquare;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] x;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    logic [31:0] exp_q[$];
    logic [31:0] src_q[$];

    fsquare dut (
        .clk       (clk),
        .rstn      (rstn),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Exact integer square of the significand, rounded by remainder comparison.
    function automatic logic [31:0] model(input logic [31:0] v);
        int     e;
        int     sh;
        int     ex;
        longint m, p, q, rem, half, one;
        logic [31:0] r;
        e   = int'(v[30:23]);
        one = 1;
        if (e == 0) return 32'h0;
        if (e == 255) return (v[22:0] != 0) ? 32'h7FC00000 : 32'h7F800000;
        m    = longint'(v[22:0]) + (one << 23);
        p    = m * m;
        sh   = (p >= (one << 47)) ? 24 : 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = one << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        ex = 2 * e - 127 + (sh - 23);
        if (q == (one << 24)) begin
            q  = q >> 1;
            ex = ex + 1;
        end
        if (ex >= 255) return 32'h7F800000;
        if (ex <= 0) return 32'h0;
        r = {1'b0, ex[7:0], q[22:0]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [31:0] v);
        int t;
        x        = v;
        in_valid = 1'b1;
        t        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("send_timeout", 32'(t), 32'd0);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        exp_q.push_back(model(v));
        src_q.push_back(v);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        logic [31:0] want, src;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", y, 32'hxxxxxxxx);
                end else begin
                    want = exp_q.pop_front();
                    src  = src_q.pop_front();
                    checks++;
                    if (y !== want) begin
                        errors++;
                        $display("FAIL result x=%h: got %h expected %h", src, y, want);
                    end
                end
            end
        end
    end

    initial begin
        int          cnt;
        logic [31:0] v;
        logic [31:0] edge_vals[5];

        rstn     = 1'b0;
        x        = 32'h0;
        in_valid = 1'b0;
        #3;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_y", y, 32'h0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed values and latency
        send(32'h40000000);
        in_valid = 1'b0;
        cnt = 1;
        while (cnt < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cnt++;
        end
        #1;
        chk("latency", 32'(cnt), 32'd3);
        chk("value_2sq", model(32'h40000000), 32'h40800000);
        idle(2);
        send(32'hC0400000);
        send(32'h3FC00000);
        send(32'h3F800001);
        edge_vals = '{32'h60AD78EC, 32'h1F800000, 32'h00000001, 32'h7FC00001, 32'hFF800000};
        foreach (edge_vals[i]) send(edge_vals[i]);
        idle(1);
        drain();

        // Backpressure: fill the pipe and stall it
        ready_mode = 1;
        idle(2);
        send(32'h40000000);
        send(32'h40400000);
        send(32'h40800000);
        x        = 32'h40A00000;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_y_hold", y, 32'h40800000);
            @(posedge clk); #1;
        end
        ready_mode = 0;
        send(32'h40A00000);
        idle(1);
        drain();

        // Randomised normals with random backpressure and gaps
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            send(v);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        for (int k = 0; k < 100; k++) send($urandom);
        ready_mode = 0;
        idle(1);
        drain();

        // Reset with three operations in flight
        send(32'h40000000);
        send(32'h40400000);
        send(32'h40800000);
        in_valid = 1'b0;
        rstn     = 1'b0;
        #1;
        chk("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_reset_y", y, 32'h0);
        exp_q.delete();
        src_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(10);
        chk("post_reset_quiet", {31'd0, out_valid}, 32'd0);
        send(32'h40A00000);
        idle(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
